// File: rtl/dmem_pkg.sv
// Shared constants and types for the data memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the full 0..15 wait-state range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for RISC-V loads/stores: byte strobes, replicated store data, extended load data, error flag.
// Latency: purely combinational. Backpressure: none, no handshake.
// DMEM_MISALIGN_CHECK_EN turns misaligned H/W accesses into errors; otherwise low address bits are dropped.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wstrb,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic        illegal;
    logic        is_h;
    logic        is_w;
    logic [1:0]  off;
    logic [15:0] lane;

    always_comb begin
        is_h    = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w    = (funct3 == F3_W);
        // Unsigned widths only make sense for loads.
        illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && funct3[2]);
`ifdef DMEM_MISALIGN_CHECK_EN
        off = addr_lo;
        err = illegal || (is_h && addr_lo[0]) || (is_w && (addr_lo != 2'b00));
`else
        off = is_w ? 2'b00 : (is_h ? {addr_lo[1], 1'b0} : addr_lo);
        err = illegal;
`endif
        lane  = 16'(rword >> {off, 3'b000});
        wstrb = 4'b0000;
        wword = wdata;
        rdata = '0;

        case (funct3)
            F3_B, F3_BU: begin
                wword = {4{wdata[7:0]}};
                wstrb = 4'b0001 << off;
            end
            F3_H, F3_HU: begin
                wword = {2{wdata[15:0]}};
                wstrb = 4'b0011 << off;
            end
            default: wstrb = 4'b1111;
        endcase

        case (funct3)
            F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   rdata = {24'h0, lane[7:0]};
            F3_H:    rdata = {{16{lane[15]}}, lane};
            F3_HU:   rdata = {16'h0, lane};
            F3_W:    rdata = rword;
            default: rdata = '0;
        endcase

        if (err || we) begin
            rdata = '0;
        end
        if (err || !we) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering single load/store requests with one-beat responses.
// Latency: response strobe WAIT_CYCLES edges after acceptance (WAIT_CYCLES+2 cycles per request).
// Backpressure: req_ready only in IDLE, no response backpressure; DMEM_MISALIGN_CHECK_EN selects misalign errors.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int WORDS       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(WORDS);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic             we_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       f3_q;

    logic             accept;
    logic             do_acc;
    logic             acc_we;
    logic [AW+1:0]    acc_addr;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_f3;

    logic [31:0]      mem [WORDS];
    logic [31:0]      rword;
    logic [31:0]      wword;
    logic [31:0]      rdata_a;
    logic [3:0]       wstrb;
    logic             err_a;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && rst_n;
        rsp_valid = (state_q == RESP);
        accept    = req_valid && req_ready;
        // With zero wait states the access shares the accept edge and uses the live request.
        do_acc    = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    end

    assign acc_we    = (state_q == IDLE) ? req_we              : we_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr[AW+1:0]    : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata           : wdata_q;
    assign acc_f3    = (state_q == IDLE) ? req_funct3          : f3_q;
    assign rword     = mem[acc_addr[AW+1:2]];

    dmem_lane_align u_align (
        .we      (acc_we),
        .addr_lo (acc_addr[1:0]),
        .funct3  (acc_f3),
        .wdata   (acc_wdata),
        .rword   (rword),
        .wstrb   (wstrb),
        .wword   (wword),
        .rdata   (rdata_a),
        .err     (err_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                cnt_q   <= CNT_W'(WAIT_CYCLES);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (do_acc) begin
                rdata_q <= rdata_a;
                err_q   <= err_a;
            end else if (state_q == RESP) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[acc_addr[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
